br_flow_mux_fixed_reg: RTL

Registered fixed-priority flow mux. Arbitrates among NumRequesters ready/valid data sources, with index 0 as the highest priority. The winner's payload and source index go into a 2-entry output buffer, so every output is driven from flops and no input is combinationally reachable from pop_ready. Sits directly downstream of the requesters, in place of a bare combinational fixed-priority flow arbiter wherever grant data must be carried and timing must be broken.

---
 rtl/br_flow_mux_fixed_reg_pkg.sv | 18 +
 rtl/br_flow_mux_fixed_reg_buf.sv | 91 +++++++++
 rtl/br_flow_mux_fixed_reg_chk.sv | 36 +++
 rtl/br_flow_mux_fixed_reg.sv | 93 +++++++++
 4 files changed

// File: rtl/br_flow_mux_fixed_reg_pkg.sv
// Shared types and helpers for the registered fixed-priority flow mux.
package br_flow_mux_fixed_reg_pkg;

    // Occupancy of the 2-entry output buffer, encoded as the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    // Bits needed to name a requester; never narrower than one bit.
    function automatic int src_width(input int num_req);
        int w;
        w = (num_req > 32'sd1) ? $clog2(num_req) : 32'sd1;
        return w;
    endfunction

endpackage

// File: rtl/br_flow_mux_fixed_reg_buf.sv
// Two-entry ready/valid buffer: head/tail slots plus an occupancy count.
// Every pop-side output comes from flops.
module br_flow_mux_fixed_reg_buf
    import br_flow_mux_fixed_reg_pkg::*;
#(
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [Width-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [Width-1:0] pop_data
);

    buf_state_e       state_r;
    buf_state_e       state_nxt_s;
    logic [Width-1:0] head_r;
    logic [Width-1:0] head_nxt_s;
    logic [Width-1:0] tail_r;
    logic [Width-1:0] tail_nxt_s;
    logic             push_s;
    logic             pop_s;

    // Handshake flags decode the state flop only; requesters are held off while in reset.
    always_comb begin
        push_ready = rst && (state_r != ST_FULL);
        pop_valid  = (state_r != ST_EMPTY);
        pop_data   = head_r;
        push_s     = push_valid && push_ready;
        pop_s      = pop_valid && pop_ready;
    end

    // Next occupancy and slot contents; a push while one entry is popping lands in head.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    state_nxt_s = ST_ONE;
                    head_nxt_s  = push_data;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_s) begin
                    if (pop_s) begin
                        head_nxt_s = push_data;
                    end else begin
                        state_nxt_s = ST_FULL;
                        tail_nxt_s  = push_data;
                    end
                end else if (pop_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    state_nxt_s = ST_ONE;
                    head_nxt_s  = tail_r;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State and slot registers; reset drops any buffered entries without popping them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
        end
    end

endmodule

// File: rtl/br_flow_mux_fixed_reg_chk.sv
// Protocol and integration checks for the registered fixed-priority flow mux.
module br_flow_mux_fixed_reg_chk #(
    parameter int NumRequesters = 2,
    parameter int Width         = 1,
    parameter int SourceWidth   = 1
) (
    input logic                     clk,
    input logic                     rst,
    input logic [NumRequesters-1:0] push_valid,
    input logic [NumRequesters-1:0] push_ready,
    input logic [Width-1:0]         push_data [NumRequesters],
    input logic [NumRequesters-1:0] grant,
    input logic                     pop_valid,
    input logic                     pop_ready,
    input logic [Width-1:0]         pop_data,
    input logic [SourceWidth-1:0]   pop_source
);

    a_params: assert property (@(posedge clk) disable iff (!rst)
        (NumRequesters >= 32'sd2) && (Width >= 32'sd1));

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(grant));

    for (genvar i = 0; i < NumRequesters; i++) begin : g_req
        a_push_hold: assert property (@(posedge clk) disable iff (!rst)
            (push_valid[i] && !push_ready[i]) |=> (push_valid[i] && $stable(push_data[i])));
    end

    a_pop_stable: assert property (@(posedge clk) disable iff (!rst)
        (pop_valid && !pop_ready) |=> (pop_valid && $stable(pop_data) && $stable(pop_source)));

    a_pop_known: assert property (@(posedge clk) disable iff (!rst)
        pop_valid |-> !$isunknown({pop_data, pop_source}));

endmodule

// File: rtl/br_flow_mux_fixed_reg.sv
// Registered fixed-priority flow mux: index 0 wins, and the winner's payload
// and index are carried through a 2-entry buffer so pop_* come from flops.
module br_flow_mux_fixed_reg
    import br_flow_mux_fixed_reg_pkg::*;
#(
    parameter  int NumRequesters = 2,
    parameter  int Width         = 1,
    localparam int SourceWidth   = src_width(NumRequesters)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NumRequesters-1:0] push_valid,
    output logic [NumRequesters-1:0] push_ready,
    input  logic [Width-1:0]         push_data [NumRequesters],
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [Width-1:0]         pop_data,
    output logic [SourceWidth-1:0]   pop_source
);

    localparam int EntryWidth = Width + SourceWidth;

    logic [NumRequesters-1:0] grant_s;
    logic [SourceWidth-1:0]   grant_idx_s;
    logic [Width-1:0]         grant_data_s;
    logic                     can_accept_s;
    logic                     lower_valid_s;
    logic [EntryWidth-1:0]    entry_s;
    logic [EntryWidth-1:0]    head_s;

    // Isolate the lowest set valid bit: that requester is the winner.
    assign grant_s = push_valid & (~push_valid + {{(NumRequesters-1){1'b0}}, 1'b1});

    // Encode the one-hot grant into a source index and select the winner's payload.
    always_comb begin
        grant_idx_s  = '0;
        grant_data_s = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            if (grant_s[i]) begin
                grant_idx_s  = SourceWidth'(i);
                grant_data_s = push_data[i];
            end else begin
                grant_idx_s  = grant_idx_s;
                grant_data_s = grant_data_s;
            end
        end
    end

    // Ready needs buffer room and no valid higher-priority requester; own valid is not used.
    always_comb begin
        lower_valid_s = 1'b0;
        push_ready    = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            push_ready[i] = can_accept_s && !lower_valid_s;
            lower_valid_s = lower_valid_s || push_valid[i];
        end
    end

    assign entry_s    = {grant_data_s, grant_idx_s};
    assign pop_data   = head_s[EntryWidth-1:SourceWidth];
    assign pop_source = head_s[SourceWidth-1:0];

    br_flow_mux_fixed_reg_buf #(
        .Width (EntryWidth)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_valid (|push_valid),
        .push_ready (can_accept_s),
        .push_data  (entry_s),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (head_s)
    );

    br_flow_mux_fixed_reg_chk #(
        .NumRequesters (NumRequesters),
        .Width         (Width),
        .SourceWidth   (SourceWidth)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .grant      (grant_s),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .pop_source (pop_source)
    );

endmodule
